// File: rtl/alsu_cmd_issuer_pkg.sv
// alsu_cmd_issuer_pkg: shared ALSU command types, latency constant and legality check
package alsu_cmd_issuer_pkg;
    typedef enum logic [2:0] {OR, XOR, ADD, MULT, SHIFT, ROTATE, INVALID_6, INVALID_7} opcode_e;
    typedef struct packed {
        logic signed [2:0] A;
        logic signed [2:0] B;
        logic              cin;
        logic              serial_in;
        logic              red_op_A;
        logic              red_op_B;
        opcode_e           opcode;
        logic              bypass_A;
        logic              bypass_B;
        logic              direction;
    } alsu_cmd_t;
    localparam int ALSU_LAT = 2;
    function automatic logic is_illegal(alsu_cmd_t c);
        return c.opcode inside {INVALID_6, INVALID_7} ||
               ((c.red_op_A || c.red_op_B) && !(c.opcode inside {OR, XOR}));
    endfunction
endpackage

// File: rtl/alsu_cmd_issuer_if.sv
// alsu_cmd_issuer_if: command valid/ready handshake and tagged result return
interface alsu_cmd_issuer_if #(parameter int TAG_W = 4);
    import alsu_cmd_issuer_pkg::*;
    logic             cmd_valid;
    alsu_cmd_t        cmd;
    logic             cmd_ready;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [5:0]       res_data;
    logic             res_err;
    modport master (output cmd_valid, cmd, input cmd_ready, res_valid, res_tag, res_data, res_err);
    modport slave  (input cmd_valid, cmd, output cmd_ready, res_valid, res_tag, res_data, res_err);
endinterface

// File: rtl/alsu_cmd_fifo.sv
// alsu_cmd_fifo: DEPTH-entry command FIFO, registered full/empty/level, no fall-through
module alsu_cmd_fifo import alsu_cmd_issuer_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  alsu_cmd_t wdata,
    output alsu_cmd_t rdata,
    output logic      full,
    output logic      empty,
    output logic [AW:0] level
);
    alsu_cmd_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] lvl_n;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign lvl_n = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign rdata = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            level <= lvl_n;
            full <= lvl_n == (AW+1)'(DEPTH);
            empty <= lvl_n == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end
endmodule

// File: rtl/alsu_cmd_issuer.sv
// alsu_cmd_issuer: queues ALSU commands, drives ALSU pins, returns tagged results (ALSU_ISS_INVALID_FILTER_EN drops illegal commands)
module alsu_cmd_issuer import alsu_cmd_issuer_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int ALSU_LAT = alsu_cmd_issuer_pkg::ALSU_LAT,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alsu_cmd_issuer_if.slave  bus,
    input  logic              issue_en,
    output logic [LW-1:0]     level,
    output logic signed [2:0] alsu_A,
    output logic signed [2:0] alsu_B,
    output logic              alsu_cin,
    output logic              alsu_serial_in,
    output logic              alsu_red_op_A,
    output logic              alsu_red_op_B,
    output opcode_e           alsu_opcode,
    output logic              alsu_bypass_A,
    output logic              alsu_bypass_B,
    output logic              alsu_direction,
    input  logic [5:0]        alsu_out,
    output logic [7:0]        drop_cnt
);
    alsu_cmd_t head, pin_q;
    logic full, empty, rdy_q, acc, push, pop;
    logic [TAG_W-1:0] tag_q;
    logic [ALSU_LAT:0] pv, pe;
    logic [TAG_W-1:0] pt [ALSU_LAT+1];
    assign bus.cmd_ready = rdy_q && !full;
    assign acc = bus.cmd_valid && bus.cmd_ready;
    assign pop = issue_en && !empty;
`ifdef ALSU_ISS_INVALID_FILTER_EN
    logic ill;
    assign ill = is_illegal(bus.cmd);
    assign push = acc && !ill;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= 8'd0;
        else if (acc && ill && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign push = acc;
    assign drop_cnt = 8'd0;
`endif
    alsu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(bus.cmd),
        .rdata(head), .full(full), .empty(empty), .level(level)
    );
    // pin registers hold across bubbles, so shift/rotate keep evolving inside the ALSU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            pin_q <= '0;
            tag_q <= '0;
            pv <= '0;
            pe <= '0;
            for (int i = 0; i <= ALSU_LAT; i++) pt[i] <= '0;
            bus.res_valid <= 1'b0;
            bus.res_tag <= '0;
            bus.res_data <= '0;
            bus.res_err <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (pop) begin
                pin_q <= head;
                tag_q <= tag_q + TAG_W'(1);
            end
            pv <= {pv[ALSU_LAT-1:0], pop};
            pe <= {pe[ALSU_LAT-1:0], pop && is_illegal(head)};
            pt[0] <= tag_q;
            for (int i = 1; i <= ALSU_LAT; i++) pt[i] <= pt[i-1];
            bus.res_valid <= pv[ALSU_LAT];
            if (pv[ALSU_LAT]) begin
                bus.res_tag <= pt[ALSU_LAT];
                bus.res_data <= alsu_out;
                bus.res_err <= pe[ALSU_LAT];
            end
        end
    end
    assign alsu_A = pin_q.A;
    assign alsu_B = pin_q.B;
    assign alsu_cin = pin_q.cin;
    assign alsu_serial_in = pin_q.serial_in;
    assign alsu_red_op_A = pin_q.red_op_A;
    assign alsu_red_op_B = pin_q.red_op_B;
    assign alsu_opcode = pin_q.opcode;
    assign alsu_bypass_A = pin_q.bypass_A;
    assign alsu_bypass_B = pin_q.bypass_B;
    assign alsu_direction = pin_q.direction;
endmodule
